// File: rtl/id_ex_issue_stage.sv
// id_ex_issue_stage: decode-to-execute boundary with a DEPTH-entry issue
// buffer, valid/ready intake, registered EX-side output and load-use
// bubble insertion over a LOAD_LAT-slot window.
// Optional build macro ISSUE_STAGE_PERF_CNT_EN adds bubble_cnt_o, a
// saturating count of load-use bubbles.
module id_ex_issue_stage #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_W-1:0]         in_payload_i,
  input  logic [4:0]                   in_rd_i,
  input  logic [4:0]                   in_rs1_i,
  input  logic [4:0]                   in_rs2_i,
  input  logic                         in_uses_rs1_i,
  input  logic                         in_uses_rs2_i,
  input  logic                         in_is_load_i,
  input  logic                         flush_i,
  input  logic                         busywait_i,
  output logic                         out_valid_o,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [4:0]                   out_rd_o,
  output logic                         out_is_load_o,
  output logic                         load_stall_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef ISSUE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]                  bubble_cnt_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 is_load;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // Tracker slot 0 mirrors the instruction in EX; older issue slots follow.
  logic [LOAD_LAT-1:0] trk_vld;
  logic [4:0]          trk_rd [LOAD_LAT];

  entry_t in_entry;
  entry_t head;
  logic   buf_empty;
  logic   head_valid;
  logic   hazard;
  logic   push;
  logic   pop;
  logic   advance;
  logic   buf_write;
  logic   buf_read;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_entry = '{payload:  in_payload_i,
                      rd:       in_rd_i,
                      rs1:      in_rs1_i,
                      rs2:      in_rs2_i,
                      uses_rs1: in_uses_rs1_i,
                      uses_rs2: in_uses_rs2_i,
                      is_load:  in_is_load_i};

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready_o = (count < CNT_W'(DEPTH)) && !rst_i;
  assign push       = in_valid_i && in_ready_o && !flush_i;
  assign advance    = !busywait_i && !flush_i;
  assign buf_empty  = (count == '0);

  // An empty buffer lets the incoming instruction act as head (fall-through).
  assign head_valid = !buf_empty || push;
  assign head       = buf_empty ? in_entry : mem[rd_ptr];

  // Load-use hazard: a read source matches the rd of any load still in the window.
  always_comb begin
    // NOTE: default first so every path assigns hazard and no latch is inferred.
    hazard = 1'b0;
    if (head_valid) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        if (trk_vld[i]) begin
          if (head.uses_rs1 && (head.rs1 != 5'd0) && (head.rs1 == trk_rd[i])) hazard = 1'b1;
          if (head.uses_rs2 && (head.rs2 != 5'd0) && (head.rs2 == trk_rd[i])) hazard = 1'b1;
        end
      end
    end
  end

  assign pop          = advance && head_valid && !hazard;
  assign load_stall_o = advance && hazard;

  // A fall-through input consumed this cycle bypasses the storage array.
  assign buf_write = push && !(buf_empty && pop);
  assign buf_read  = pop && !buf_empty;
  assign count_o   = count;

  // Entry storage; validity comes solely from count and the pointers.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; stale entries are never read.
    if (buf_write) mem[wr_ptr] <= in_entry;
  end

  // Pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (buf_write) wr_ptr <= ptr_inc(wr_ptr);
      if (buf_read)  rd_ptr <= ptr_inc(rd_ptr);
      case ({buf_write, buf_read})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // EX register and load tracker: hold under busywait, shift on advance.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_valid_o   <= 1'b0;
      out_payload_o <= '0;
      out_rd_o      <= '0;
      out_is_load_o <= 1'b0;
      trk_vld       <= '0;
      for (int i = 0; i < LOAD_LAT; i++) trk_rd[i] <= '0;
    end else if (advance) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        trk_vld[i] <= trk_vld[i-1];
        trk_rd[i]  <= trk_rd[i-1];
      end
      if (pop) begin
        out_valid_o   <= 1'b1;
        out_payload_o <= head.payload;
        out_rd_o      <= head.rd;
        out_is_load_o <= head.is_load;
        trk_vld[0]    <= head.is_load;
        trk_rd[0]     <= head.rd;
      end else begin
        out_valid_o   <= 1'b0;
        out_payload_o <= '0;
        out_rd_o      <= '0;
        out_is_load_o <= 1'b0;
        trk_vld[0]    <= 1'b0;
        trk_rd[0]     <= '0;
      end
    end
  end

`ifdef ISSUE_STAGE_PERF_CNT_EN
  // Saturating load-use bubble counter; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  bubble_cnt_o <= '0;
    else if (load_stall_o && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Bench for id_ex_issue_stage: two instances (DEPTH=2/LOAD_LAT=1 and
// DEPTH=3/LOAD_LAT=2) share one stimulus stream; a queue-level model is
// compared every cycle, plus hand-computed literal expectations.
module tb_id_ex_issue_stage;

  localparam int PW = 160;

  typedef struct packed {
    logic [PW-1:0] pl;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          u1;
    logic          u2;
    logic          ld;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_pl;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic          in_u1, in_u2, in_ld;
  logic          flush, busy;

  logic          rdy   [2];
  logic          ov    [2];
  logic [PW-1:0] opl   [2];
  logic [4:0]    ord   [2];
  logic          old   [2];
  logic          stall [2];
  logic [1:0]    cnt   [2];
`ifdef ISSUE_STAGE_PERF_CNT_EN
  logic [31:0]   bub   [2];
`endif

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  int seq = 0;

  always #5 clk = ~clk;

  id_ex_issue_stage #(.PAYLOAD_W(PW), .DEPTH(2), .LOAD_LAT(1)) u0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .in_payload_i(in_pl), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_uses_rs1_i(in_u1), .in_uses_rs2_i(in_u2), .in_is_load_i(in_ld),
    .flush_i(flush), .busywait_i(busy), .out_valid_o(ov[0]), .out_payload_o(opl[0]),
    .out_rd_o(ord[0]), .out_is_load_o(old[0]), .load_stall_o(stall[0]), .count_o(cnt[0])
`ifdef ISSUE_STAGE_PERF_CNT_EN
    , .bubble_cnt_o(bub[0])
`endif
  );

  id_ex_issue_stage #(.PAYLOAD_W(PW), .DEPTH(3), .LOAD_LAT(2)) u1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .in_payload_i(in_pl), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
    .in_uses_rs1_i(in_u1), .in_uses_rs2_i(in_u2), .in_is_load_i(in_ld),
    .flush_i(flush), .busywait_i(busy), .out_valid_o(ov[1]), .out_payload_o(opl[1]),
    .out_rd_o(ord[1]), .out_is_load_o(old[1]), .load_stall_o(stall[1]), .count_o(cnt[1])
`ifdef ISSUE_STAGE_PERF_CNT_EN
    , .bubble_cnt_o(bub[1])
`endif
  );

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: pending FIFO contents (index 0 = oldest), what sits in EX,
  // and the {is_load, rd} of the last LOAD_LAT issue slots (0 = newest).
  int            mdepth [2] = '{2, 3};
  int            mlat   [2] = '{1, 2};
  ent_t          mq     [2][8];
  int            msz    [2];
  logic          ex_v   [2];
  logic [PW-1:0] ex_pl  [2];
  logic [4:0]    ex_rd  [2];
  logic          ex_ld  [2];
  logic          hv     [2][4];
  logic [4:0]    hrd    [2][4];
  logic [31:0]   bcnt   [2];

  task automatic model_clear(input int k, input logic clr_cnt);
    msz[k] = 0;
    ex_v[k] = 1'b0; ex_pl[k] = '0; ex_rd[k] = '0; ex_ld[k] = 1'b0;
    for (int j = 0; j < 4; j++) begin hv[k][j] = 1'b0; hrd[k][j] = '0; end
    if (clr_cnt) bcnt[k] = '0;
  endtask

  task automatic model_cycle(input int k);
    ent_t inn, head;
    logic exp_rdy, push, hvld, haz, from_in, popped;
    inn.pl = in_pl; inn.rd = in_rd; inn.rs1 = in_rs1; inn.rs2 = in_rs2;
    inn.u1 = in_u1; inn.u2 = in_u2; inn.ld = in_ld;

    exp_rdy = !rst && (msz[k] < mdepth[k]);
    check($sformatf("u%0d.in_ready", k), PW'(rdy[k]), PW'(exp_rdy));
    check($sformatf("u%0d.out_valid", k), PW'(ov[k]), PW'(ex_v[k]));
    check($sformatf("u%0d.out_rd", k), PW'(ord[k]), PW'(ex_rd[k]));
    check($sformatf("u%0d.out_is_load", k), PW'(old[k]), PW'(ex_ld[k]));
    check($sformatf("u%0d.out_payload", k), opl[k], ex_pl[k]);
    check($sformatf("u%0d.count", k), PW'(cnt[k]), PW'(msz[k]));
`ifdef ISSUE_STAGE_PERF_CNT_EN
    check($sformatf("u%0d.bubble_cnt", k), PW'(bub[k]), PW'(bcnt[k]));
`endif
    if (rst) begin
      model_clear(k, 1'b1);
      return;
    end

    push = in_valid && exp_rdy && !flush;
    from_in = 1'b0;
    hvld = 1'b1;
    head = '0;
    if (msz[k] > 0) head = mq[k][0];
    else if (push) begin head = inn; from_in = 1'b1; end
    else hvld = 1'b0;

    haz = 1'b0;
    if (hvld)
      for (int j = 0; j < mlat[k]; j++)
        if (hv[k][j] && ((head.u1 && head.rs1 != 0 && head.rs1 == hrd[k][j]) ||
                         (head.u2 && head.rs2 != 0 && head.rs2 == hrd[k][j])))
          haz = 1'b1;
    check($sformatf("u%0d.load_stall", k), PW'(stall[k]), PW'(!flush && !busy && haz));

    if (flush) begin
      model_clear(k, 1'b0);
    end else if (busy) begin
      if (push) begin mq[k][msz[k]] = inn; msz[k]++; end
    end else begin
      for (int j = mlat[k] - 1; j > 0; j--) begin
        hv[k][j] = hv[k][j-1];
        hrd[k][j] = hrd[k][j-1];
      end
      popped = hvld && !haz;
      if (popped) begin
        ex_v[k] = 1'b1; ex_pl[k] = head.pl; ex_rd[k] = head.rd; ex_ld[k] = head.ld;
        hv[k][0] = head.ld; hrd[k][0] = head.rd;
        if (!from_in) begin
          for (int j = 0; j < msz[k] - 1; j++) mq[k][j] = mq[k][j+1];
          msz[k]--;
        end
      end else begin
        ex_v[k] = 1'b0; ex_pl[k] = '0; ex_rd[k] = '0; ex_ld[k] = 1'b0;
        hv[k][0] = 1'b0; hrd[k][0] = '0;
        if (haz && bcnt[k] != 32'hFFFF_FFFF) bcnt[k]++;
      end
      if (push && !(popped && from_in)) begin mq[k][msz[k]] = inn; msz[k]++; end
    end
  endtask

  // Compare process: every cycle, both instances, away from the active edge.
  always @(negedge clk) begin
    if (chk_en)
      for (int k = 0; k < 2; k++) model_cycle(k);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [PW-1:0] mk_pl(input int n);
    logic [31:0] v;
    v = 32'(n);
    return {v, ~v, v ^ 32'hA5A5_A5A5, v + 32'd1, v * 32'd3};
  endfunction

  task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic ld);
    in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_u1 = u1; in_u2 = u2; in_ld = ld;
    seq++;
    in_pl = mk_pl(seq);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_u1 = 1'b0; in_u2 = 1'b0; in_ld = 1'b0; in_pl = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear(0, 1'b1);
    model_clear(1, 1'b1);
    rst = 1'b1; flush = 1'b0; busy = 1'b0;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("rdy after reset", PW'(rdy[0]), PW'(1));

    // Fall-through: single ALU op reaches EX one cycle later, buffer stays empty.
    drive(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    check("ft out_valid", PW'(ov[0]), PW'(1));
    check("ft out_rd", PW'(ord[0]), PW'(5));
    check("ft count", PW'(cnt[0]), PW'(0));
    tick();
    check("ft then bubble", PW'(ov[0]), PW'(0));

    // Load-use: LW x3 then consumer of x3.
    drive(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(5'd6, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu u0 stall", PW'(stall[0]), PW'(1));
    check("lu u1 stall", PW'(stall[1]), PW'(1));
    check("lu lw in ex rd", PW'(ord[0]), PW'(3));
    check("lu lw in ex ld", PW'(old[0]), PW'(1));
    tick();
    idle();
    check("lu u0 bubble", PW'(ov[0]), PW'(0));
    check("lu u0 count", PW'(cnt[0]), PW'(1));
    check("lu u1 bubble1", PW'(ov[1]), PW'(0));
    tick();
    check("lu u0 add ex", PW'(ord[0]), PW'(6));
    check("lu u0 add valid", PW'(ov[0]), PW'(1));
    check("lu u1 bubble2", PW'(ov[1]), PW'(0));
    check("lu u1 count", PW'(cnt[1]), PW'(1));
    tick();
    check("lu u1 add ex", PW'(ord[1]), PW'(6));
    tick();

    // x0 destination never stalls.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check("x0 u0 no stall", PW'(stall[0]), PW'(0));
    check("x0 u1 no stall", PW'(stall[1]), PW'(0));
    tick();
    idle();
    check("x0 add ex", PW'(ord[0]), PW'(6));

    // Matching label that is not actually read does not stall.
    drive(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(5'd7, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0);
    #1 check("unused rs1 no stall", PW'(stall[0]), PW'(0));
    tick();
    idle();
    tick();

    // Busywait with continuous pushes: buffer fills, EX holds, then drains in order.
    drive(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(5'(8 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("bw count full", PW'(cnt[0]), PW'(2));
    check("bw not ready", PW'(rdy[0]), PW'(0));
    check("bw ex held", PW'(ord[0]), PW'(7));
    busy = 1'b0;
    idle();
    tick();
    check("bw drain 1", PW'(ord[0]), PW'(8));
    tick();
    check("bw drain 2", PW'(ord[0]), PW'(9));
    tick();
    check("bw drained", PW'(cnt[0]), PW'(0));
    for (int i = 0; i < 3; i++) tick();

    // Flush beats busywait and a simultaneous push.
    busy = 1'b1;
    drive(5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd21, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("fl pre count", PW'(cnt[0]), PW'(2));
    flush = 1'b1;
    drive(5'd22, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    busy = 1'b0;
    idle();
    check("fl count", PW'(cnt[0]), PW'(0));
    check("fl out_valid", PW'(ov[0]), PW'(0));
    for (int i = 0; i < 3; i++) tick();

    // Reset mid-stream with a full buffer.
    busy = 1'b1;
    drive(5'd24, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd25, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rs pre count", PW'(cnt[0]), PW'(2));
    rst = 1'b1;
    busy = 1'b0;
    idle();
    #1 check("rs ready low", PW'(rdy[0]), PW'(0));
    tick();
    check("rs count", PW'(cnt[0]), PW'(0));
    check("rs out_valid", PW'(ov[0]), PW'(0));
    rst = 1'b0;
    #1 check("rs ready back", PW'(rdy[0]), PW'(1));

    // Three load-use pairs; bubble counter counts them and survives a flush.
    for (int p = 0; p < 3; p++) begin
      drive(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(5'd6, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) tick();
    end
`ifdef ISSUE_STAGE_PERF_CNT_EN
    check("perf u0 three", PW'(bub[0]), PW'(3));
    check("perf u1 six", PW'(bub[1]), PW'(6));
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef ISSUE_STAGE_PERF_CNT_EN
    check("perf after flush", PW'(bub[0]), PW'(3));
`endif

    // Mixed traffic with small register labels to provoke hazards.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      else
        idle();
      busy  = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 11) == 0);
      tick();
    end
    idle();
    busy = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
Parametrised successor to the decode/execute pipeline boundary. Replaces the single ID/EX register with a DEPTH-entry issue buffer, a valid/ready input handshake and a registered EX-side output. Carries an opaque decoded payload of PAYLOAD_W bits. Tracks loads in flight over a configurable LOAD_LAT window and inserts load-use bubbles. Sits between the decoder and the EX stage; flush comes from branch resolution, freeze comes from memory busywait.

Parameters:
PAYLOAD_W, 160, width of the opaque decoded-instruction payload (imm, ALU/BMU/MDU ops, CSR fields, pc, ...)
DEPTH, 2, issue buffer entries; legal range 1..8
LOAD_LAT, 1, number of issue slots after a load in which its rd is unavailable; legal range 1..4

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  decoder presents an instruction
in_ready_o  out  1  buffer can accept; equals (count < DEPTH) && !rst_i
in_payload_i  in  PAYLOAD_W  decoded payload
in_rd_i  in  5  destination label (0 = no write)
in_rs1_i, in_rs2_i  in  5 each  source labels
in_uses_rs1_i, in_uses_rs2_i  in  1 each  source actually read
in_is_load_i  in  1  instruction is a load (incl. LR)
flush_i  in  1  branch/exception flush
busywait_i  in  1  freeze EX boundary
out_valid_o  out  1  EX slot holds a real instruction
out_payload_o  out  PAYLOAD_W  EX payload
out_rd_o  out  5  EX destination label
out_is_load_o  out  1  EX instruction is a load
load_stall_o  out  1  bubble inserted this cycle because of load-use hazard (combinational)
count_o  out  $clog2(DEPTH+1)  buffer occupancy

Behaviour:
- Reset (rst_i=1 at posedge): count=0, all out_* = 0, load tracker cleared. in_ready_o=0 while rst_i is high.
- Push: in_valid_i && in_ready_o && !flush_i. in_ready_o depends on the registered count only, never on same-cycle pop.
- Head: the oldest buffer entry. If count==0, the input itself is the head (fall-through), so ID->EX latency is 1 cycle when there is no hazard.
- Load tracker: LOAD_LAT-deep shift register of {valid, rd}. Slot 0 mirrors the instruction currently in EX. It shifts only on advance cycles.
- Hazard: head uses rs1 (or rs2), the label is nonzero, and it equals the rd of any valid tracker slot. rd=x0 never causes a hazard.
- Advance cycle (busywait_i=0, flush_i=0):
  - Head present, no hazard: head pops into the out register, out_valid_o=1, and the tracker shifts in {in_is_load, rd}.
  - Hazard: bubble. out_valid_o=0, out_* payload zeroed, load_stall_o=1, head retained, tracker shifts in {0,0}.
  - No head: bubble, load_stall_o=0.
- busywait_i=1 and flush_i=0: out register and tracker hold. Pushes still accepted while space remains. load_stall_o=0.
- flush_i=1: overrides busywait_i and any push. Buffer emptied (count=0), out register zeroed, tracker cleared. The input is dropped.
- Simultaneous push and pop: count unchanged. A fall-through input consumed the same cycle is not written to the buffer.
- Ordering: strict FIFO; a hazarded head blocks everything behind it.
- Counter arithmetic: count never exceeds DEPTH or drops below 0. Pointers wrap modulo DEPTH; DEPTH need not be a power of two.

Optional Feature:
ISSUE_STAGE_PERF_CNT_EN defined: adds output bubble_cnt_o [31:0]. It increments on each advance cycle where load_stall_o=1, saturates at 0xFFFFFFFF, and is cleared by reset (flush does not clear it). When undefined: no port and no counter logic.

Test Plan:
- Reset mid-stream with count=2 -> next cycle count_o=0, out_valid_o=0, in_ready_o=1 once rst_i=0.
- Empty buffer, push ADD rd=5, no busywait -> out_valid_o=1 next cycle with out_rd_o=5, count_o stays 0.
- LOAD_LAT=1: push LW rd=3 then ADD rs1=3 back-to-back -> one bubble (load_stall_o=1 for one cycle); ADD reaches EX 2 cycles after LW. LOAD_LAT=2 -> 2 bubbles. Repeat with rd=0 -> no bubble.
- busywait_i=1 for 5 cycles with in_valid_i=1 and DEPTH=2 -> count_o reaches 2, in_ready_o=0, out register unchanged. On release, entries drain in order.
- flush_i=1 together with busywait_i=1 and a valid push, count=2 -> next cycle count_o=0, out_valid_o=0, pushed instruction absent from all later outputs.
- With ISSUE_STAGE_PERF_CNT_EN: 3 load-use pairs at LOAD_LAT=1 -> bubble_cnt_o=3; a flush leaves it at 3.
